pipe_stage_reg: RTL and testbench

//  Generic parametrised inter-stage pipeline register for OpenMIPS, replacing hand-written stage latches (ex/mem-style).

---
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall/flush/bubble handling and a multi-cycle carry channel.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned          PAYLOAD_W = 32*8,
    parameter logic [PAYLOAD_W-1:0] NOP_VALUE = {PAYLOAD_W{1'b0}},
    parameter int unsigned          CARRY_W   = 64,
    parameter int unsigned          CNT_W     = 2,
    parameter int unsigned          UP_IDX    = 3,
    parameter int unsigned          PERF_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           stall,
    input  logic                 flush,
    input  logic                 up_valid,
    input  logic [PAYLOAD_W-1:0] up_payload,
    input  logic [CARRY_W-1:0]   carry_i,
    input  logic [CNT_W-1:0]     cnt_i,
    output logic                 dn_valid,
    output logic [PAYLOAD_W-1:0] dn_payload,
    output logic [CARRY_W-1:0]   carry_o,
    output logic [CNT_W-1:0]     cnt_o,
    input  logic                 perf_clr,
    output logic [PERF_W-1:0]    perf_adv,
    output logic [PERF_W-1:0]    perf_bub,
    output logic [PERF_W-1:0]    perf_hold,
    output logic [PERF_W-1:0]    perf_flush
);

    localparam int unsigned DN_IDX = UP_IDX + 1;

    generate
        if (UP_IDX > 4) begin : g_bad_up_idx
            $error("pipe_stage_reg: UP_IDX must be in 0..4");
        end
    endgenerate

    typedef enum logic [2:0] {
        OP_RESET,
        OP_FLUSH,
        OP_BUBBLE,
        OP_ADVANCE,
        OP_HOLD
    } op_e;

    logic up_stall;
    logic dn_stall;
    op_e  op;

    assign up_stall = stall[UP_IDX];
    assign dn_stall = stall[DN_IDX];

    // The illegal U=0,D=1 combination falls through to ADVANCE.
    always_comb begin
        op = OP_HOLD;
        if (rst)
            op = OP_RESET;
        else if (flush)
            op = OP_FLUSH;
        else if (up_stall && !dn_stall)
            op = OP_BUBBLE;
        else if (!up_stall)
            op = OP_ADVANCE;
    end

    always_ff @(posedge clk) begin
        case (op)
            OP_RESET, OP_FLUSH: begin
                dn_valid   <= 1'b0;
                dn_payload <= NOP_VALUE;
                carry_o    <= '0;
                cnt_o      <= '0;
            end
            OP_BUBBLE: begin
                dn_valid   <= 1'b0;
                dn_payload <= NOP_VALUE;
                carry_o    <= carry_i;
                cnt_o      <= cnt_i;
            end
            OP_ADVANCE: begin
                dn_valid   <= up_valid;
                dn_payload <= up_valid ? up_payload : NOP_VALUE;
                carry_o    <= '0;
                cnt_o      <= '0;
            end
            default: begin
                carry_o    <= carry_i;
                cnt_o      <= cnt_i;
            end
        endcase
    end

    // The stall vector from ctrl is monotone, so a stalled downstream implies a stalled upstream.
    assert property (@(posedge clk) disable iff (rst) !(!up_stall && dn_stall));

`ifdef PIPE_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Counters saturate; reset and perf_clr both win over any increment.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_adv   <= '0;
            perf_bub   <= '0;
            perf_hold  <= '0;
            perf_flush <= '0;
        end else begin
            case (op)
                OP_ADVANCE: if (up_valid) perf_adv <= sat_inc(perf_adv);
                OP_BUBBLE:  perf_bub   <= sat_inc(perf_bub);
                OP_HOLD:    perf_hold  <= sat_inc(perf_hold);
                OP_FLUSH:   perf_flush <= sat_inc(perf_flush);
                default:    ;
            endcase
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;

    assign perf_adv   = '0;
    assign perf_bub   = '0;
    assign perf_hold  = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized legal traffic against a rule-level model.
module tb_pipe_stage_reg;

    localparam int PW  = 256;
    localparam int CW  = 64;
    localparam int NW  = 2;
    localparam int UP  = 3;
    localparam int PFW = 4;
    localparam int PMAX = 15;
    localparam logic [PW-1:0] NOP = {32{8'h3C}};

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          up_valid;
    logic [PW-1:0] up_payload;
    logic [CW-1:0] carry_i;
    logic [NW-1:0] cnt_i;
    logic          dn_valid;
    logic [PW-1:0] dn_payload;
    logic [CW-1:0] carry_o;
    logic [NW-1:0] cnt_o;
    logic          perf_clr;
    logic [PFW-1:0] perf_adv, perf_bub, perf_hold, perf_flush;

    int checks = 0;
    int failures = 0;

    // Reference state, derived directly from the stage rules
    logic          m_valid;
    logic [PW-1:0] m_payload;
    logic [CW-1:0] m_carry;
    logic [NW-1:0] m_cnt;
    int m_adv, m_bub, m_hold, m_flush;

    pipe_stage_reg #(
        .PAYLOAD_W(PW), .NOP_VALUE(NOP), .CARRY_W(CW), .CNT_W(NW), .UP_IDX(UP), .PERF_W(PFW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .up_valid(up_valid), .up_payload(up_payload), .carry_i(carry_i), .cnt_i(cnt_i),
        .dn_valid(dn_valid), .dn_payload(dn_payload), .carry_o(carry_o), .cnt_o(cnt_o),
        .perf_clr(perf_clr), .perf_adv(perf_adv), .perf_bub(perf_bub),
        .perf_hold(perf_hold), .perf_flush(perf_flush)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v >= PMAX) ? PMAX : v + 1;
    endfunction

    function automatic logic [PFW-1:0] exp_perf(input int v);
`ifdef PIPE_PERF_EN
        return PFW'(v);
`else
        return '0;
`endif
    endfunction

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] p;
        for (int i = 0; i < PW/32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    // Advance one clock with the currently driven inputs and update the model.
    task automatic step();
        logic u, d;
        u = stall[UP];
        d = stall[UP+1];
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_payload = NOP; m_carry = '0; m_cnt = '0;
            m_adv = 0; m_bub = 0; m_hold = 0; m_flush = 0;
        end else begin
            if (flush) begin
                m_valid = 1'b0; m_payload = NOP; m_carry = '0; m_cnt = '0;
            end else if (u && !d) begin
                m_valid = 1'b0; m_payload = NOP; m_carry = carry_i; m_cnt = cnt_i;
            end else if (!u) begin
                m_valid = up_valid; m_payload = up_valid ? up_payload : NOP;
                m_carry = '0; m_cnt = '0;
            end else begin
                m_carry = carry_i; m_cnt = cnt_i;
            end
            if (perf_clr) begin
                m_adv = 0; m_bub = 0; m_hold = 0; m_flush = 0;
            end else if (flush) m_flush = sat(m_flush);
            else if (u && !d) m_bub = sat(m_bub);
            else if (!u) begin
                if (up_valid) m_adv = sat(m_adv);
            end else m_hold = sat(m_hold);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] s, input logic f, input logic v,
                                 input logic [PW-1:0] p, input logic [CW-1:0] c,
                                 input logic [NW-1:0] n, input logic pc);
        stall = s; flush = f; up_valid = v; up_payload = p; carry_i = c; cnt_i = n; perf_clr = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(6'b000000, 1'($urandom), 1'($urandom), rand_payload(),
                          {$urandom, $urandom}, 2'($urandom), 1'b0);
            step();
            checks++;
            if (dn_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", dn_valid); end
            checks++;
            if (dn_payload !== NOP) begin failures++; $display("[TB] FAIL reset_payload: got %h want %h", dn_payload, NOP); end
            checks++;
            if (carry_o !== '0 || cnt_o !== '0) begin
                failures++; $display("[TB] FAIL reset_carry: got %h/%0d want 0/0", carry_o, cnt_o);
            end
            checks++;
            if ({perf_adv, perf_bub, perf_hold, perf_flush} !== '0) begin
                failures++; $display("[TB] FAIL reset_perf: got %h %h %h %h want 0", perf_adv, perf_bub, perf_hold, perf_flush);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_advance();
        applyStimulus(6'b000000, 1'b0, 1'b1, {32{8'hA5}}, 64'h0, 2'd0, 1'b0);
        step();
        checks++;
        if (dn_valid !== 1'b1 || dn_payload !== {32{8'hA5}}) begin
            failures++; $display("[TB] FAIL advance_valid: got %b/%h want 1/a5..", dn_valid, dn_payload);
        end
        applyStimulus(6'b000000, 1'b0, 1'b0, {32{8'hA5}}, 64'h0, 2'd0, 1'b0);
        step();
        checks++;
        if (dn_valid !== 1'b0 || dn_payload !== NOP) begin
            failures++; $display("[TB] FAIL advance_invalid: got %b/%h want 0/%h", dn_valid, dn_payload, NOP);
        end
    endtask

    task automatic test_bubble();
        applyStimulus(6'b000000, 1'b0, 1'b1, rand_payload(), 64'h0, 2'd0, 1'b0);
        step();
        applyStimulus(6'b001111, 1'b0, 1'b1, rand_payload(), 64'h1234, 2'd1, 1'b0);
        step();
        checks++;
        if (dn_valid !== 1'b0 || dn_payload !== NOP) begin
            failures++; $display("[TB] FAIL bubble_valid: got %b/%h want 0/%h", dn_valid, dn_payload, NOP);
        end
        checks++;
        if (carry_o !== 64'h1234 || cnt_o !== 2'd1) begin
            failures++; $display("[TB] FAIL bubble_carry: got %h/%0d want 1234/1", carry_o, cnt_o);
        end
        applyStimulus(6'b000000, 1'b0, 1'b0, rand_payload(), 64'h1234, 2'd1, 1'b0);
        step();
        checks++;
        if (carry_o !== '0 || cnt_o !== '0) begin
            failures++; $display("[TB] FAIL advance_carry_clear: got %h/%0d want 0/0", carry_o, cnt_o);
        end
    endtask

    task automatic test_hold();
        applyStimulus(6'b000000, 1'b0, 1'b1, {32{8'h55}}, 64'h0, 2'd0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'b011111, 1'b0, 1'b1, rand_payload(), {$urandom, $urandom}, 2'($urandom), 1'b0);
            step();
            checks++;
            if (dn_valid !== 1'b1 || dn_payload !== {32{8'h55}}) begin
                failures++; $display("[TB] FAIL hold_payload: got %b/%h want 1/55..", dn_valid, dn_payload);
            end
            checks++;
            if (carry_o !== carry_i || cnt_o !== cnt_i) begin
                failures++; $display("[TB] FAIL hold_carry: got %h/%0d want %h/%0d", carry_o, cnt_o, carry_i, cnt_i);
            end
        end
        checks++;
        if (perf_hold !== exp_perf(3) || perf_adv !== exp_perf(0)) begin
            failures++; $display("[TB] FAIL hold_perf: got hold=%0d adv=%0d want %0d/%0d",
                                 perf_hold, perf_adv, exp_perf(3), exp_perf(0));
        end
    endtask

    task automatic test_flush();
        applyStimulus(6'b011111, 1'b1, 1'b1, rand_payload(), 64'hFF, 2'd3, 1'b0);
        step();
        checks++;
        if (dn_valid !== 1'b0 || dn_payload !== NOP || carry_o !== '0 || cnt_o !== '0) begin
            failures++; $display("[TB] FAIL flush_state: got %b/%h/%h/%0d want 0/nop/0/0", dn_valid, dn_payload, carry_o, cnt_o);
        end
        checks++;
        if (perf_flush !== exp_perf(1) || perf_hold !== exp_perf(3)) begin
            failures++; $display("[TB] FAIL flush_perf: got flush=%0d hold=%0d want %0d/%0d",
                                 perf_flush, perf_hold, exp_perf(1), exp_perf(3));
        end
    endtask

    task automatic test_saturate();
        applyStimulus(6'b000000, 1'b0, 1'b0, NOP, 64'h0, 2'd0, 1'b1);
        step();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(6'b001111, 1'b0, 1'($urandom), rand_payload(), {$urandom, $urandom}, 2'($urandom), 1'b0);
            step();
        end
        checks++;
        if (perf_bub !== exp_perf(15)) begin
            failures++; $display("[TB] FAIL bub_saturate: got %0d want %0d", perf_bub, exp_perf(15));
        end
        applyStimulus(6'b001111, 1'b0, 1'b1, rand_payload(), 64'h0, 2'd0, 1'b1);
        step();
        checks++;
        if (perf_bub !== '0) begin
            failures++; $display("[TB] FAIL bub_clear: got %0d want 0", perf_bub);
        end
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 6);
            rst = ($urandom_range(0, 99) < 3);
            applyStimulus(6'((1 << k) - 1), ($urandom_range(0, 99) < 10), 1'($urandom), rand_payload(),
                          {$urandom, $urandom}, 2'($urandom), ($urandom_range(0, 99) < 5));
            step();
            checks++;
            if (dn_valid !== m_valid || dn_payload !== m_payload || carry_o !== m_carry || cnt_o !== m_cnt) begin
                failures++;
                $display("[TB] FAIL random_state cyc=%0d: got %b/%h/%h/%0d want %b/%h/%h/%0d", i,
                         dn_valid, dn_payload, carry_o, cnt_o, m_valid, m_payload, m_carry, m_cnt);
            end
            checks++;
            if (perf_adv !== exp_perf(m_adv) || perf_bub !== exp_perf(m_bub) ||
                perf_hold !== exp_perf(m_hold) || perf_flush !== exp_perf(m_flush)) begin
                failures++;
                $display("[TB] FAIL random_perf cyc=%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                         perf_adv, perf_bub, perf_hold, perf_flush,
                         exp_perf(m_adv), exp_perf(m_bub), exp_perf(m_hold), exp_perf(m_flush));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(6'b000000, 1'b0, 1'b0, NOP, 64'h0, 2'd0, 1'b0);
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
